mem_be_clr: RTL and testbench
=============================

# mem_be_clr

Parametrised single-port synchronous memory with per-byte write enables, a configurable registered read latency with a valid strobe, and a sequential clear engine. Clearing runs after reset and on request. It replaces the fixed 8×8 memory as the general storage block for datapath buffers. Requesters see a `ready`/`busy` handshake instead of a one-cycle array wipe.

## Interface
Parameters:
- `WIDTH`, 32: data word width in bits; must be a multiple of 8.
- `DEPTH`, 16: number of words; any value ≥ 2.
- `ADDR_W`, `$clog2(DEPTH)`: address width.
- `BE_W`, `WIDTH/8`: byte-enable width.
- `READ_LAT`, 1: read latency in cycles; legal values are 1 and 2.

Ports:
- `clk`, in, 1: the only clock; all logic on its rising edge.
- `rst`, in, 1: synchronous, active-low reset.
- `req`, in, 1: access request.
- `wen`, in, 1: with `req`, 1 = write, 0 = read.
- `be`, in, BE_W: byte enables for writes; ignored on reads.
- `addr`, in, ADDR_W: word address.
- `wdata`, in, WIDTH: write data.
- `clr`, in, 1: single-cycle request to zero the whole array.
- `ready`, out, 1: block accepts `req` this cycle.
- `busy`, out, 1: clear engine active; always `~ready`.
- `rdata`, out, WIDTH: read data.
- `rvalid`, out, 1: one-cycle pulse marking `rdata` valid.

## Operation
- FSM states:
  - ST_CLEAR: one word per cycle at the clear counter `cptr` is written to 0; `cptr` increments. On the cycle `cptr == DEPTH-1`, next state is ST_IDLE.
  - ST_IDLE: normal access.
- Transitions:
  - Reset forces ST_CLEAR with `cptr = 0`.
  - `clr` high in ST_IDLE gives ST_CLEAR next cycle with `cptr = 0`.
  - `clr` high during ST_CLEAR is ignored; the walk is not restarted.
- Handshake:
  - A transaction is accepted only on `req && ready`.
  - `req` while `!ready` has no effect and is not queued.
  - `ready = (state == ST_IDLE)`.
- Write (accepted, `wen=1`):
  - For each i with `be[i]=1`, `mem[addr][8i+7:8i] <= wdata[8i+7:8i]`. Other bytes are unchanged.
  - `be = 0` is a legal no-op.
  - A write produces no `rvalid` and leaves `rdata` unchanged.
- Read (accepted, `wen=0`):
  - The array word is sampled at the accept edge.
  - It appears on `rdata` with `rvalid=1` exactly READ_LAT cycles after acceptance.
  - `rdata` holds its last value between reads; `rvalid` is otherwise 0.
- Out-of-range `addr` (≥ DEPTH, only possible when DEPTH is not a power of 2):
  - A write is dropped.
  - A read returns 0 with a normal `rvalid`.
- Simultaneous events:
  - `clr` and `req` in the same ST_IDLE cycle: the request is accepted and executed; the clear starts next cycle.
  - A read accepted before a clear returns pre-clear data, even if it completes during ST_CLEAR.
  - Reads may be issued back-to-back every cycle. With READ_LAT=2, up to two reads are in flight.
- Read-after-write: a read of the same address on the cycle after a write returns the new data.

## Timing
- While `rst=0` at a rising edge:
  - `rdata=0`, `rvalid=0`, read pipeline flushed.
  - State ST_CLEAR, `cptr=0`, so `busy=1` and `ready=0`.
  - The array is not wiped in one cycle.
- Reset mid-operation: in-flight reads are discarded (no `rvalid`), and the clear walk restarts from 0.
- After reset release: the first edge with `rst=1` clears word 0.
- Clear duration: exactly DEPTH cycles of `busy=1`, from reset release or from the cycle after `clr`. `ready` rises on the following cycle.
- Read latency: READ_LAT cycles from the accept edge to `rvalid`. Write latency: visible to a read accepted on the next edge.
- No combinational path from any input to any output.

## Structure
- Shared package `mem_pkg`:
  - `typedef enum logic {ST_CLEAR, ST_IDLE} mem_state_t`.
  - `localparam BYTE_W = 8`.
- Elaboration checks: `WIDTH % 8 == 0`, `READ_LAT` in {1, 2}, `DEPTH >= 2`.
- Sub-module `mem_rd_pipe`: a READ_LAT-deep delay line for {valid, data} with reset flush. The top level holds the array, FSM and `cptr`.

## Test plan
All cases use `WIDTH=32`, `DEPTH=16`.
- **Reset clear**:
  - Stimulus: hold `rst=0` 3 cycles, release.
  - Required: `busy=1` for exactly 16 cycles, then `ready=1`. Reading all 16 addresses returns `0x00000000`.
- **Byte enables**:
  - Stimulus: write `0xAABBCCDD` to addr 5 with `be=4'hF`, then `0x11223344` with `be=4'b0101`, then read addr 5.
  - Required: `rdata=0xAA22CC44`, with `rvalid` READ_LAT cycles after accept (check READ_LAT=1 and 2).
- **Back-to-back reads with READ_LAT=2**:
  - Stimulus: addr 1 holds `0x1`, addr 2 holds `0x2`; read addr 1 then addr 2 on consecutive cycles.
  - Required: `rvalid` high two consecutive cycles, returning `0x1` then `0x2`.
- **`clr` with same-cycle read**:
  - Stimulus: addr 3 holds `0x55`; read addr 3 together with `clr`.
  - Required: the read returns `0x55`; `busy` rises next cycle for 16 cycles; a later read of addr 3 returns 0.
- **Request during clear**:
  - Stimulus: issue a write of `0xFF` to addr 7 while `busy=1`.
  - Required: the write is ignored; after the clear, a read of addr 7 returns 0.
- **Reset mid-read**:
  - Stimulus: READ_LAT=2; accept a read, then drive `rst=0` the next cycle.
  - Required: no `rvalid`, `rdata=0`, and the clear walk restarts at `cptr=0`.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the byte-enable memory with clear engine.
package mem_pkg;
  typedef enum logic {ST_CLEAR, ST_IDLE} mem_state_t;
  localparam int BYTE_W = 8;
endpackage

// File: rtl/mem_rd_pipe.sv
// Read-return delay line: LAT cycles from in_vld to out_vld, no backpressure.
// Every data stage holds its last value, so out_dat is stable between reads.
module mem_rd_pipe #(
  parameter int WIDTH = 32,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_dat
);
  logic [LAT-1:0]   vld;
  logic [WIDTH-1:0] dat [LAT];

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld <= '0;
      for (int i = 0; i < LAT; i++) dat[i] <= '0;
    end else begin
      vld[0] <= in_vld;
      if (in_vld) dat[0] <= in_dat;
      for (int i = 1; i < LAT; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) dat[i] <= dat[i-1];
      end
    end
  end

  assign out_vld = vld[LAT-1];
  assign out_dat = dat[LAT-1];
endmodule

// File: rtl/mem_be_clr.sv
// Single-port memory with byte enables, READ_LAT-cycle registered reads and a
// one-word-per-cycle clear walk; requests are refused (ready=0) while clearing.
module mem_be_clr
  import mem_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int BE_W     = WIDTH / 8,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              wen,
  input  logic [BE_W-1:0]   be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              clr,
  output logic              ready,
  output logic              busy,
  output logic [WIDTH-1:0]  rdata,
  output logic              rvalid
);
  generate
    if (WIDTH % BYTE_W != 0) begin : g_bad_width
      $error("mem_be_clr: WIDTH must be a multiple of 8");
    end
    if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_lat
      $error("mem_be_clr: READ_LAT must be 1 or 2");
    end
    if (DEPTH < 2) begin : g_bad_depth
      $error("mem_be_clr: DEPTH must be at least 2");
    end
  endgenerate

  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);

  mem_state_t        state, state_nxt;
  logic [ADDR_W-1:0] cptr, cptr_nxt;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic              acc, in_range;
  logic [WIDTH-1:0]  rd_word;

  assign ready    = (state == ST_IDLE);
  assign busy     = ~ready;
  assign acc      = req && ready;
  assign in_range = ({1'b0, addr} < DEPTH_X);
  assign rd_word  = in_range ? mem[addr] : '0;

  // clr while already clearing is ignored: only ST_IDLE looks at it
  always_comb begin
    state_nxt = state;
    cptr_nxt  = cptr;
    case (state)
      ST_CLEAR: begin
        cptr_nxt = cptr + ADDR_W'(1);
        if (cptr == LAST) begin
          state_nxt = ST_IDLE;
          cptr_nxt  = '0;
        end
      end
      ST_IDLE: begin
        if (clr) begin
          state_nxt = ST_CLEAR;
          cptr_nxt  = '0;
        end
      end
      default: begin
        state_nxt = ST_CLEAR;
        cptr_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_CLEAR;
      cptr  <= '0;
    end else begin
      state <= state_nxt;
      cptr  <= cptr_nxt;
    end
  end

  // Array has no reset; the clear walk is what zeroes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state == ST_CLEAR) begin
        mem[cptr] <= '0;
      end else if (acc && wen && in_range) begin
        for (int b = 0; b < BE_W; b++) begin
          if (be[b]) mem[addr][b*BYTE_W +: BYTE_W] <= wdata[b*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  mem_rd_pipe #(
    .WIDTH (WIDTH),
    .LAT   (READ_LAT)
  ) u_rd_pipe (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (acc && !wen),
    .in_dat  (rd_word),
    .out_vld (rvalid),
    .out_dat (rdata)
  );
endmodule

// File: tb/tb_mem_be_clr.sv
// Bench: two instances (READ_LAT=1 and 2) share stimulus and are checked every
// cycle against a transaction-level model (array + pending-read queues).
module tb_mem_be_clr;
  localparam int W = 32;
  localparam int D = 16;

  typedef struct {
    int          due;
    logic [31:0] d;
  } pend_t;

  logic        clk = 1'b0;
  logic        rst, req, wen, clr;
  logic [3:0]  be, addr;
  logic [31:0] wdata;
  logic        ready1, busy1, rvalid1, ready2, busy2, rvalid2;
  logic [31:0] rdata1, rdata2;

  always #5 clk = ~clk;

  mem_be_clr #(.WIDTH(W), .DEPTH(D), .READ_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .req(req), .wen(wen), .be(be), .addr(addr),
    .wdata(wdata), .clr(clr), .ready(ready1), .busy(busy1),
    .rdata(rdata1), .rvalid(rvalid1)
  );

  mem_be_clr #(.WIDTH(W), .DEPTH(D), .READ_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .req(req), .wen(wen), .be(be), .addr(addr),
    .wdata(wdata), .clr(clr), .ready(ready2), .busy(busy2),
    .rdata(rdata2), .rvalid(rvalid2)
  );

  int          checks = 0;
  int          failures = 0;
  logic [31:0] ref_mem [D];
  int          clr_left = D;
  int          cyc = 0;
  pend_t       q1[$], q2[$];
  logic [31:0] last1 = '0, last2 = '0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic zero_ref();
    for (int i = 0; i < D; i++) ref_mem[i] = '0;
  endtask

  // Applies the inputs present at this rising edge to the model.
  task automatic model_edge();
    cyc++;
    if (!rst) begin
      clr_left = D;
      zero_ref();
      q1.delete();
      q2.delete();
      last1 = '0;
      last2 = '0;
    end else if (clr_left > 0) begin
      clr_left--;
    end else begin
      if (req) begin
        if (wen) begin
          for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[addr][8*b +: 8] = wdata[8*b +: 8];
        end else begin
          q1.push_back('{due: cyc, d: ref_mem[addr]});
          q2.push_back('{due: cyc + 1, d: ref_mem[addr]});
        end
      end
      if (clr) begin
        clr_left = D;
        zero_ref();
      end
    end
  endtask

  task automatic check_outs();
    check_val("ready1", {31'b0, ready1}, {31'b0, clr_left == 0});
    check_val("busy1", {31'b0, busy1}, {31'b0, clr_left != 0});
    check_val("ready2", {31'b0, ready2}, {31'b0, clr_left == 0});
    check_val("busy2", {31'b0, busy2}, {31'b0, clr_left != 0});
    if (q1.size() > 0 && q1[0].due == cyc) begin
      check_val("rvalid1", {31'b0, rvalid1}, 32'd1);
      last1 = q1[0].d;
      void'(q1.pop_front());
    end else begin
      check_val("rvalid1", {31'b0, rvalid1}, 32'd0);
    end
    check_val("rdata1", rdata1, last1);
    if (q2.size() > 0 && q2[0].due == cyc) begin
      check_val("rvalid2", {31'b0, rvalid2}, 32'd1);
      last2 = q2[0].d;
      void'(q2.pop_front());
    end else begin
      check_val("rvalid2", {31'b0, rvalid2}, 32'd0);
    end
    check_val("rdata2", rdata2, last2);
  endtask

  task automatic do_cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outs();
  endtask

  task automatic idle();
    req = 1'b0; wen = 1'b0; clr = 1'b0; be = '0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
    req = 1'b1; wen = 1'b1; addr = a; wdata = d; be = b;
    do_cycle();
    idle();
  endtask

  task automatic rd(input logic [3:0] a);
    req = 1'b1; wen = 1'b0; addr = a;
    do_cycle();
    idle();
  endtask

  task automatic count_busy(input string tag);
    int n = 0;
    while (busy1 && n < 40) begin
      n++;
      do_cycle();
    end
    check_val(tag, n, 32'd16);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; addr = '0; wdata = '0;
    idle();
    zero_ref();

    // reset clear: 3 reset cycles, then exactly 16 busy cycles
    repeat (3) do_cycle();
    rst = 1'b1;
    count_busy("reset_busy_len");
    for (int a = 0; a < D; a++) rd(4'(a));
    repeat (2) do_cycle();

    // byte enables
    wr(4'd5, 32'hAABBCCDD, 4'hF);
    wr(4'd5, 32'h11223344, 4'b0101);
    rd(4'd5);
    do_cycle();
    check_val("be_merge_lat1", rdata1, 32'hAA22CC44);
    check_val("be_merge_lat2", rdata2, 32'hAA22CC44);

    // back-to-back reads
    wr(4'd1, 32'h1, 4'hF);
    wr(4'd2, 32'h2, 4'hF);
    rd(4'd1);
    rd(4'd2);
    repeat (2) do_cycle();

    // clr with same-cycle read
    wr(4'd3, 32'h55, 4'hF);
    req = 1'b1; wen = 1'b0; addr = 4'd3; clr = 1'b1;
    do_cycle();
    idle();
    check_val("clr_rd_lat1", rdata1, 32'h55);
    count_busy("clr_busy_len");
    rd(4'd3);
    do_cycle();
    check_val("clr_after_rd", rdata2, 32'h0);

    // request during clear
    wr(4'd7, 32'hDEADBEEF, 4'hF);
    clr = 1'b1;
    do_cycle();
    idle();
    wr(4'd7, 32'hFF, 4'hF);
    for (int i = 0; i < 40 && busy1; i++) do_cycle();
    rd(4'd7);
    do_cycle();
    check_val("busy_wr_dropped", rdata2, 32'h0);

    // reset mid-read
    wr(4'd9, 32'h12345678, 4'hF);
    rd(4'd9);
    rst = 1'b0;
    do_cycle();
    check_val("rst_midread_rvalid2", {31'b0, rvalid2}, 32'd0);
    check_val("rst_midread_rdata2", rdata2, 32'h0);
    rst = 1'b1;
    count_busy("rst_midread_busy_len");

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst   = ($urandom_range(0, 199) != 0);
      req   = 1'($urandom_range(0, 1));
      wen   = 1'($urandom_range(0, 1));
      be    = 4'($urandom_range(0, 15));
      addr  = 4'($urandom_range(0, D - 1));
      wdata = $urandom;
      clr   = ($urandom_range(0, 39) == 0);
      do_cycle();
    end
    rst = 1'b1;
    idle();
    repeat (20) do_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
